// File: rtl/vga_timing_analyzer_if.sv
// rtl/vga_timing_analyzer_if.sv - timing stream in, recovered coordinates and measurements out
interface vga_timing_analyzer_if #(
   parameter int HCNT_W = 11,
   parameter int VCNT_W = 10
);
   logic              hsync_n_i;
   logic              vsync_n_i;
   logic              blank_n_i;
   logic              pixel_valid_o;
   logic [HCNT_W-1:0] x_o;
   logic [VCNT_W-1:0] y_o;
   logic              end_of_line_o;
   logic              end_of_frame_o;
   logic [HCNT_W-1:0] h_total_o;
   logic [VCNT_W-1:0] v_total_o;
   logic              locked_o;

   // timing source side: drives the sync stream, observes the results
   modport master (
      output hsync_n_i, vsync_n_i, blank_n_i,
      input  pixel_valid_o, x_o, y_o, end_of_line_o, end_of_frame_o,
             h_total_o, v_total_o, locked_o
   );

   // analyzer side
   modport slave (
      input  hsync_n_i, vsync_n_i, blank_n_i,
      output pixel_valid_o, x_o, y_o, end_of_line_o, end_of_frame_o,
             h_total_o, v_total_o, locked_o
   );
endinterface

// File: rtl/vga_timing_analyzer.sv
// rtl/vga_timing_analyzer.sv - recovers pixel coordinates, line/frame lengths and lock from a VGA timing stream
module vga_timing_analyzer #(
   parameter int HCNT_W      = 11,
   parameter int VCNT_W      = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   vga_timing_analyzer_if.slave bus
);
   localparam int                SCNT_W   = $clog2(LOCK_FRAMES + 1);
   localparam logic [SCNT_W-1:0] LOCK_CNT = SCNT_W'(LOCK_FRAMES);
   localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
   localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

   // input stage: registered sample, its previous value, and a primed flag
   logic in_vld_q;
   logic hs_s_q, vs_s_q, bl_s_q;
   logic hs_p_q, vs_p_q, bl_p_q;

   // internal counters and measurement state
   logic [HCNT_W-1:0] x_q, x_d;
   logic [VCNT_W-1:0] y_q, y_d;
   logic [HCNT_W-1:0] hcount_q, hcount_d;
   logic [VCNT_W-1:0] vcount_q, vcount_d;
   logic              h_meas_q, h_meas_d;
   logic              v_meas_q, v_meas_d;
   logic              h_have_q, h_have_d;
   logic              v_have_q, v_have_d;
   logic              frame_ok_q, frame_ok_d;
   logic [SCNT_W-1:0] stable_q, stable_d;

   // output registers
   logic              pv_q, pv_d;
   logic [HCNT_W-1:0] xo_q, xo_d;
   logic [VCNT_W-1:0] yo_q, yo_d;
   logic              eol_q, eol_d;
   logic              eof_q, eof_d;
   logic [HCNT_W-1:0] h_total_q, h_total_d;
   logic [VCNT_W-1:0] v_total_q, v_total_d;
   logic              locked_q, locked_d;

   logic              hs_fall, vs_fall, bl_fall;
   logic              h_sat, v_sat;
   logic [HCNT_W-1:0] h_len;
   logic              h_mis, v_match;

   assign hs_fall = hs_p_q & ~hs_s_q;
   assign vs_fall = vs_p_q & ~vs_s_q;
   assign bl_fall = bl_p_q & ~bl_s_q;
   assign h_sat   = (hcount_q == HCNT_MAX);
   assign v_sat   = (vcount_q == VCNT_MAX);
   assign h_len   = hcount_q + 1'b1;

   // sample the asynchronous-looking stream; idle-high reset keeps the first compare edge-free
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         in_vld_q <= 1'b0;
         hs_s_q   <= 1'b1;
         vs_s_q   <= 1'b1;
         bl_s_q   <= 1'b1;
         hs_p_q   <= 1'b1;
         vs_p_q   <= 1'b1;
         bl_p_q   <= 1'b1;
      end else begin
         in_vld_q <= 1'b1;
         hs_s_q   <= bus.hsync_n_i;
         vs_s_q   <= bus.vsync_n_i;
         bl_s_q   <= bus.blank_n_i;
         hs_p_q   <= hs_s_q;
         vs_p_q   <= vs_s_q;
         bl_p_q   <= bl_s_q;
      end
   end

   // next-state for coordinates, measurements and lock; nothing moves until a real sample is held
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      hcount_d   = hcount_q;
      vcount_d   = vcount_q;
      h_meas_d   = h_meas_q;
      v_meas_d   = v_meas_q;
      h_have_d   = h_have_q;
      v_have_d   = v_have_q;
      frame_ok_d = frame_ok_q;
      stable_d   = stable_q;
      pv_d       = pv_q;
      xo_d       = xo_q;
      yo_d       = yo_q;
      eol_d      = eol_q;
      eof_d      = eof_q;
      h_total_d  = h_total_q;
      v_total_d  = v_total_q;
      locked_d   = locked_q;
      h_mis      = 1'b0;
      v_match    = 1'b0;

      if (in_vld_q) begin
         pv_d  = bl_s_q;
         xo_d  = bl_s_q ? x_q : '0;
         yo_d  = bl_s_q ? y_q : '0;
         eol_d = bl_fall;
         eof_d = vs_fall;

         if (bl_fall) begin
            x_d = '0;
         end else if (bl_s_q) begin
            x_d = x_q + 1'b1;
         end

         // a frame start wins over a line end landing on the same cycle
         if (vs_fall) begin
            y_d = '0;
         end else if (bl_fall) begin
            y_d = y_q + 1'b1;
         end

         // a saturated count means sync was lost, so it is never taken as a length
         if (hs_fall) begin
            hcount_d = '0;
            h_meas_d = 1'b1;
            if (h_meas_q && !h_sat) begin
               h_total_d = h_len;
               h_have_d  = 1'b1;
               h_mis     = h_have_q && (h_len != h_total_q);
            end
         end else if (!h_sat) begin
            hcount_d = hcount_q + 1'b1;
         end

         // an hs_fall coinciding with vs_fall belongs to the new frame
         if (vs_fall) begin
            vcount_d = {{(VCNT_W-1){1'b0}}, hs_fall};
            v_meas_d = 1'b1;
            if (v_meas_q && !v_sat) begin
               v_total_d = vcount_q;
               v_have_d  = 1'b1;
               v_match   = v_have_q && (vcount_q == v_total_q);
            end
         end else if (hs_fall && !v_sat) begin
            vcount_d = vcount_q + 1'b1;
         end

         if (vs_fall) begin
            if (v_match && frame_ok_q) begin
               stable_d = (stable_q == LOCK_CNT) ? LOCK_CNT : stable_q + 1'b1;
            end else begin
               stable_d = '0;
            end
            frame_ok_d = 1'b1;
         end

         if (h_mis || h_sat || v_sat) begin
            stable_d   = '0;
            frame_ok_d = 1'b0;
         end

         locked_d = (stable_d == LOCK_CNT);
      end
   end

   // state and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q        <= '0;
         y_q        <= '0;
         hcount_q   <= '0;
         vcount_q   <= '0;
         h_meas_q   <= 1'b0;
         v_meas_q   <= 1'b0;
         h_have_q   <= 1'b0;
         v_have_q   <= 1'b0;
         frame_ok_q <= 1'b0;
         stable_q   <= '0;
         pv_q       <= 1'b0;
         xo_q       <= '0;
         yo_q       <= '0;
         eol_q      <= 1'b0;
         eof_q      <= 1'b0;
         h_total_q  <= '0;
         v_total_q  <= '0;
         locked_q   <= 1'b0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         hcount_q   <= hcount_d;
         vcount_q   <= vcount_d;
         h_meas_q   <= h_meas_d;
         v_meas_q   <= v_meas_d;
         h_have_q   <= h_have_d;
         v_have_q   <= v_have_d;
         frame_ok_q <= frame_ok_d;
         stable_q   <= stable_d;
         pv_q       <= pv_d;
         xo_q       <= xo_d;
         yo_q       <= yo_d;
         eol_q      <= eol_d;
         eof_q      <= eof_d;
         h_total_q  <= h_total_d;
         v_total_q  <= v_total_d;
         locked_q   <= locked_d;
      end
   end

   assign bus.pixel_valid_o  = pv_q;
   assign bus.x_o            = xo_q;
   assign bus.y_o            = yo_q;
   assign bus.end_of_line_o  = eol_q;
   assign bus.end_of_frame_o = eof_q;
   assign bus.h_total_o      = h_total_q;
   assign bus.v_total_o      = v_total_q;
   assign bus.locked_o       = locked_q;
endmodule

// File: tb/tb_vga_timing_analyzer.sv
// tb/tb_vga_timing_analyzer.sv - scoreboard bench for vga_timing_analyzer
module tb_vga_timing_analyzer;
   localparam int HW   = 11;
   localparam int VW   = 10;
   localparam int LOCK = 2;
   localparam int HMAX = (1 << HW) - 1;
   localparam int VMAX = (1 << VW) - 1;

   typedef struct {
      longint          due;
      logic            pv;
      logic [HW-1:0]   x;
      logic [VW-1:0]   y;
      logic            eol;
      logic            eof;
      logic [HW-1:0]   h;
      logic [VW-1:0]   v;
      logic            lk;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     compared = 0;
   int     mismatched = 0;
   exp_t   q[$];

   vga_timing_analyzer_if #(.HCNT_W(HW), .VCNT_W(VW)) bus ();

   vga_timing_analyzer #(.HCNT_W(HW), .VCNT_W(VW), .LOCK_FRAMES(LOCK)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // reference model: line/frame rules expressed on sample timestamps
   int m_t, m_last_hs, m_lines, m_x, m_y, m_h_tot, m_v_tot, m_stable;
   bit m_phs, m_pvs, m_pbl, m_hs_started, m_vs_started, m_h_known, m_v_known, m_clean;

   task automatic model_reset();
      m_t = 0; m_last_hs = -1; m_lines = 0; m_x = 0; m_y = 0;
      m_h_tot = 0; m_v_tot = 0; m_stable = 0;
      m_phs = 1; m_pvs = 1; m_pbl = 1;
      m_hs_started = 0; m_vs_started = 0; m_h_known = 0; m_v_known = 0; m_clean = 0;
   endtask

   task automatic model_step(input logic h, input logic v, input logic b, output exp_t e);
      bit hsf, vsf, blf, hsat, vsat, bad, good;
      int since;
      hsf = m_phs && !h;
      vsf = m_pvs && !v;
      blf = m_pbl && !b;
      since = m_t - m_last_hs - 1;
      hsat = since >= HMAX;
      vsat = m_lines >= VMAX;
      bad = hsat || vsat;
      e.pv  = b;
      e.x   = b ? HW'(m_x) : '0;
      e.y   = b ? VW'(m_y) : '0;
      e.eol = blf;
      e.eof = vsf;
      if (blf) m_x = 0; else if (b) m_x++;
      if (vsf) m_y = 0; else if (blf) m_y++;
      if (hsf) begin
         if (m_hs_started && !hsat) begin
            if (m_h_known && (since + 1) != m_h_tot) bad = 1;
            m_h_tot = since + 1;
            m_h_known = 1;
         end
         m_hs_started = 1;
         m_last_hs = m_t;
      end
      if (vsf) begin
         good = m_vs_started && !vsat && m_v_known && (m_lines == m_v_tot) && m_clean;
         if (m_vs_started && !vsat) begin
            m_v_tot = m_lines;
            m_v_known = 1;
         end
         m_stable = good ? ((m_stable + 1 > LOCK) ? LOCK : m_stable + 1) : 0;
         m_clean = 1;
         m_vs_started = 1;
         m_lines = hsf ? 1 : 0;
      end else if (hsf && !vsat) begin
         m_lines++;
      end
      if (bad) begin
         m_stable = 0;
         m_clean = 0;
      end
      e.h  = HW'(m_h_tot);
      e.v  = VW'(m_v_tot);
      e.lk = (m_stable == LOCK);
      m_phs = h; m_pvs = v; m_pbl = b;
      m_t++;
   endtask

   // monitor: pop the prediction due this cycle and compare the whole output set
   always @(negedge clk) begin
      if (q.size() != 0 && q[0].due == cyc) begin
         exp_t e;
         e = q.pop_front();
         compared++;
         if ({bus.pixel_valid_o, bus.x_o, bus.y_o, bus.end_of_line_o, bus.end_of_frame_o,
              bus.h_total_o, bus.v_total_o, bus.locked_o} !==
             {e.pv, e.x, e.y, e.eol, e.eof, e.h, e.v, e.lk}) begin
            mismatched++;
            $display("FAIL outputs cycle=%0d got pv=%0d x=%0d y=%0d eol=%0d eof=%0d h=%0d v=%0d lk=%0d need pv=%0d x=%0d y=%0d eol=%0d eof=%0d h=%0d v=%0d lk=%0d",
                     cyc, bus.pixel_valid_o, bus.x_o, bus.y_o, bus.end_of_line_o, bus.end_of_frame_o,
                     bus.h_total_o, bus.v_total_o, bus.locked_o,
                     e.pv, e.x, e.y, e.eol, e.eof, e.h, e.v, e.lk);
         end
      end
   end

   task automatic check_val(input string name, input longint got, input longint need);
      compared++;
      if (got != need) begin
         mismatched++;
         $display("FAIL %s got=%0d need=%0d", name, got, need);
      end
   endtask

   task automatic drive(input logic h, input logic v, input logic b);
      exp_t e;
      bus.hsync_n_i = h;
      bus.vsync_n_i = v;
      bus.blank_n_i = b;
      model_step(h, v, b, e);
      e.due = cyc + 2;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic push_zero(input longint due);
      exp_t e;
      e = '{due: due, pv: 1'b0, x: '0, y: '0, eol: 1'b0, eof: 1'b0, h: '0, v: '0, lk: 1'b0};
      q.push_back(e);
   endtask

   // one reset cycle; the sample that reset swallows is dropped from the scoreboard
   task automatic do_reset();
      while (q.size() != 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      rst = 1'b1;
      bus.hsync_n_i = 1'b1;
      bus.vsync_n_i = 1'b1;
      bus.blank_n_i = 1'b1;
      push_zero(cyc + 1);
      push_zero(cyc + 2);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // one frame: sync lines, back porch, active lines, front porch
   task automatic gen_frame(input int ha, input int hf, input int hsw, input int hb,
                            input int va, input int vf, input int vsw, input int vb,
                            input int voff, input int stretch_ln, input int abort_ln, input int abort_px);
      int nl, ll;
      logic hv, vv, bv;
      nl = vsw + vb + va + vf;
      for (int l = 0; l < nl; l++) begin
         ll = ha + hf + hsw + hb + ((l == stretch_ln) ? 1 : 0);
         for (int p = 0; p < ll; p++) begin
            if (l == abort_ln && p == abort_px) begin
               do_reset();
               return;
            end
            hv = !(p >= ha + hf && p < ha + hf + hsw);
            vv = !((l > 0 || p >= voff) && (l < vsw || (l == vsw && p < voff)));
            bv = (l >= vsw + vb) && (l < vsw + vb + va) && (p < ha);
            drive(hv, vv, bv);
         end
      end
   endtask

   task automatic std_frame(input int stretch_ln, input int abort_ln, input int abort_px);
      gen_frame(40, 4, 6, 6, 20, 2, 2, 3, 44, stretch_ln, abort_ln, abort_px);
   endtask

   initial begin
      int ha, hf, hsw, hb, va, vf, vsw, vb, voff;
      bus.hsync_n_i = 1'b1;
      bus.vsync_n_i = 1'b1;
      bus.blank_n_i = 1'b1;
      do_reset();

      // clean stream, vsync coincident with hsync
      repeat (5) std_frame(-1, -1, -1);
      check_val("h_total_clean", bus.h_total_o, 56);
      check_val("v_total_clean", bus.v_total_o, 27);
      check_val("locked_clean", bus.locked_o, 1);

      // one line stretched by a clock, then relock
      std_frame(10, -1, -1);
      check_val("locked_after_stretch", bus.locked_o, 0);
      repeat (3) std_frame(-1, -1, -1);
      check_val("relocked", bus.locked_o, 1);

      // hsync stuck high past saturation
      repeat (2100) drive(1'b1, 1'b1, 1'b0);
      check_val("locked_hsat", bus.locked_o, 0);
      check_val("h_total_hsat", bus.h_total_o, 56);
      repeat (4) std_frame(-1, -1, -1);
      check_val("locked_after_hsat", bus.locked_o, 1);

      // reset in the middle of an active line
      std_frame(-1, 10, 20);
      repeat (5) std_frame(-1, -1, -1);
      check_val("locked_after_reset", bus.locked_o, 1);
      check_val("h_total_after_reset", bus.h_total_o, 56);

      // randomized timings and vsync phase
      for (int it = 0; it < 3; it++) begin
         ha = $urandom_range(30, 4);  hf = $urandom_range(4, 1);
         hsw = $urandom_range(6, 1);  hb = $urandom_range(6, 1);
         va = $urandom_range(12, 3);  vf = $urandom_range(3, 1);
         vsw = $urandom_range(3, 1);  vb = $urandom_range(3, 1);
         voff = $urandom_range(ha + hf + hsw + hb - 1, 0);
         repeat (5) gen_frame(ha, hf, hsw, hb, va, vf, vsw, vb, voff, -1, -1, -1);
         check_val("h_total_rand", bus.h_total_o, ha + hf + hsw + hb);
         check_val("v_total_rand", bus.v_total_o, vsw + vb + va + vf);
         check_val("locked_rand", bus.locked_o, 1);
      end

      repeat (3) drive(1'b1, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_val("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end
endmodule
